// File: rtl/stream_burst_gen.sv
// +----------------------------------------------------------------------------+
// | stream_burst_gen: splits MMIO copy commands into 4 KB-safe AXI3 read/write |
// | burst requests and tracks outstanding write responses.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_burst_gen_chan #(
    parameter int BPB       = 8,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_beats,
    input  logic        enable,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [31:0] req_addr,
    output logic [3:0]  req_len,
    output logic        idle
);

    localparam int          c_align     = $clog2(BPB);
    localparam logic [31:0] c_max_burst = 32'(MAX_BURST);

    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic        valid_q, valid_d;
    logic [3:0]  len_q, len_d;

    logic [12:0] w_page_beats;
    logic [31:0] w_page32;
    logic [31:0] w_cap;
    logic [3:0]  w_len;
    logic [31:0] w_beats;
    logic [31:0] w_bytes;

    // Beats left before the next 4 KB boundary (addr is always BPB-aligned).
    assign w_page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> c_align;
    assign w_page32     = {19'd0, w_page_beats};
    assign w_cap        = (w_page32 < c_max_burst) ? w_page32 : c_max_burst;
    assign w_len        = (rem_q < w_cap) ? (rem_q[3:0] - 4'd1) : (w_cap[3:0] - 4'd1);
    assign w_beats      = {28'd0, len_q} + 32'd1;
    assign w_bytes      = w_beats << c_align;

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        len_d   = len_q;
        if (load) begin
            addr_d  = load_addr;
            rem_d   = load_beats;
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (req_ready) begin
                valid_d = 1'b0;
                addr_d  = addr_q + w_bytes;
                rem_d   = rem_q - w_beats;
            end
        end else if (enable && (rem_q != 32'd0)) begin
            valid_d = 1'b1;
            len_d   = w_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            rem_q   <= 32'd0;
            valid_q <= 1'b0;
            len_q   <= 4'd0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            len_q   <= len_d;
        end
    end

    assign req_valid = valid_q;
    assign req_addr  = addr_q;
    assign req_len   = len_q;
    assign idle      = (rem_q == 32'd0) && !valid_q;

endmodule

module stream_burst_gen #(
    parameter int BPB             = 8,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        MMIO_VALID,
    output logic        MMIO_READY,
    input  logic [31:0] MMIO_CMD,
    input  logic [31:0] STREAM_SRC,
    input  logic [31:0] STREAM_DEST,
    input  logic [31:0] STREAM_LEN,
    output logic        RD_REQ_VALID,
    input  logic        RD_REQ_READY,
    output logic [31:0] RD_REQ_ADDR,
    output logic [3:0]  RD_REQ_LEN,
    output logic        WR_REQ_VALID,
    input  logic        WR_REQ_READY,
    output logic [31:0] WR_REQ_ADDR,
    output logic [3:0]  WR_REQ_LEN,
    input  logic        WR_DONE,
    output logic        CMD_ERR
);

    localparam int             c_align      = $clog2(BPB);
    localparam int             c_ow         = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]    c_align_mask = ~(32'(BPB) - 32'd1);
    localparam logic [c_ow-1:0] c_out_max   = c_ow'(MAX_OUTSTANDING);
    localparam logic [c_ow-1:0] c_out_one   = c_ow'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            cmd_err_q, cmd_err_d;
    logic [c_ow-1:0] out_q, out_d;

    logic [7:0]  w_opcode;
    logic [31:0] w_beats;
    logic        w_start;
    logic        w_rd_idle;
    logic        w_wr_idle;
    logic        w_wr_hs;
    logic        w_done;
    logic        w_wr_enable;
    logic        w_unused;

    assign w_opcode    = MMIO_CMD[7:0];
    assign w_beats     = STREAM_LEN >> c_align;
    assign w_start     = (state_q == IDLE) && MMIO_VALID && (w_opcode == 8'd1) && (w_beats != 32'd0);
    assign w_wr_hs     = WR_REQ_VALID && WR_REQ_READY;
    assign w_done      = WR_DONE && (out_q != '0);
    assign w_wr_enable = (state_q == ISSUE) && (out_q != c_out_max);
    assign w_unused    = ^MMIO_CMD[31:8];

    stream_burst_gen_chan #(
        .BPB       (BPB),
        .MAX_BURST (MAX_BURST)
    ) u_rd (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .load       (w_start),
        .load_addr  (STREAM_SRC & c_align_mask),
        .load_beats (w_beats),
        .enable     (state_q == ISSUE),
        .req_ready  (RD_REQ_READY),
        .req_valid  (RD_REQ_VALID),
        .req_addr   (RD_REQ_ADDR),
        .req_len    (RD_REQ_LEN),
        .idle       (w_rd_idle)
    );

    stream_burst_gen_chan #(
        .BPB       (BPB),
        .MAX_BURST (MAX_BURST)
    ) u_wr (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .load       (w_start),
        .load_addr  (STREAM_DEST & c_align_mask),
        .load_beats (w_beats),
        .enable     (w_wr_enable),
        .req_ready  (WR_REQ_READY),
        .req_valid  (WR_REQ_VALID),
        .req_addr   (WR_REQ_ADDR),
        .req_len    (WR_REQ_LEN),
        .idle       (w_wr_idle)
    );

    // A handshake and a response in the same cycle cancel out.
    always_comb begin
        out_d = out_q;
        case ({w_wr_hs, w_done})
            2'b10:   out_d = out_q + c_out_one;
            2'b01:   out_d = out_q - c_out_one;
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_err_d = cmd_err_q;
        case (state_q)
            IDLE: begin
                if (MMIO_VALID) begin
                    cmd_err_d = (w_opcode > 8'd1);
                    if (w_start) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (w_rd_idle && w_wr_idle) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            cmd_err_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_err_q <= cmd_err_d;
            out_q     <= out_d;
        end
    end

    assign MMIO_READY = (state_q == IDLE);
    assign CMD_ERR    = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_burst_gen.sv
// +----------------------------------------------------------------------------+
// | tb_stream_burst_gen: scoreboard bench for stream_burst_gen.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_stream_burst_gen;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        MMIO_VALID = 1'b0;
    logic        MMIO_READY;
    logic [31:0] MMIO_CMD = '0;
    logic [31:0] STREAM_SRC = '0;
    logic [31:0] STREAM_DEST = '0;
    logic [31:0] STREAM_LEN = '0;
    logic        RD_REQ_VALID;
    logic        RD_REQ_READY = 1'b1;
    logic [31:0] RD_REQ_ADDR;
    logic [3:0]  RD_REQ_LEN;
    logic        WR_REQ_VALID;
    logic        WR_REQ_READY = 1'b1;
    logic [31:0] WR_REQ_ADDR;
    logic [3:0]  WR_REQ_LEN;
    logic        WR_DONE;
    logic        CMD_ERR;

    logic done_auto = 1'b0;
    logic done_man  = 1'b0;
    bit   auto_en   = 1'b1;
    assign WR_DONE = done_auto | done_man;

    stream_burst_gen dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .MMIO_VALID   (MMIO_VALID),
        .MMIO_READY   (MMIO_READY),
        .MMIO_CMD     (MMIO_CMD),
        .STREAM_SRC   (STREAM_SRC),
        .STREAM_DEST  (STREAM_DEST),
        .STREAM_LEN   (STREAM_LEN),
        .RD_REQ_VALID (RD_REQ_VALID),
        .RD_REQ_READY (RD_REQ_READY),
        .RD_REQ_ADDR  (RD_REQ_ADDR),
        .RD_REQ_LEN   (RD_REQ_LEN),
        .WR_REQ_VALID (WR_REQ_VALID),
        .WR_REQ_READY (WR_REQ_READY),
        .WR_REQ_ADDR  (WR_REQ_ADDR),
        .WR_REQ_LEN   (WR_REQ_LEN),
        .WR_DONE      (WR_DONE),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } req_t;

    req_t rd_exp[$];
    req_t wr_exp[$];
    int total = 0;
    int bad = 0;
    int rd_hs = 0;
    int wr_hs = 0;
    int done_cnt = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever a request handshake is presented.
    always @(negedge ACLK) begin
        req_t e;
        if (ARESETN) begin
            if (RD_REQ_VALID && RD_REQ_READY) begin
                rd_hs++;
                if (rd_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got addr %0h len %0d required none", RD_REQ_ADDR, RD_REQ_LEN);
                end else begin
                    e = rd_exp.pop_front();
                    check("rd_addr", 64'(RD_REQ_ADDR), 64'(e.addr));
                    check("rd_len", 64'(RD_REQ_LEN), 64'(e.len));
                end
            end
            if (WR_REQ_VALID && WR_REQ_READY) begin
                wr_hs++;
                if (wr_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got addr %0h len %0d required none", WR_REQ_ADDR, WR_REQ_LEN);
                end else begin
                    e = wr_exp.pop_front();
                    check("wr_addr", 64'(WR_REQ_ADDR), 64'(e.addr));
                    check("wr_len", 64'(WR_REQ_LEN), 64'(e.len));
                end
                if (auto_en) begin
                    fork
                        begin
                            repeat (4) @(posedge ACLK);
                            #1 done_auto = 1'b1;
                            @(posedge ACLK);
                            #1 done_auto = 1'b0;
                        end
                    join_none
                end
            end
            if (WR_DONE) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [31:0] cmd, input logic [31:0] src,
                        input logic [31:0] dst, input logic [31:0] len);
        MMIO_CMD    = cmd;
        STREAM_SRC  = src;
        STREAM_DEST = dst;
        STREAM_LEN  = len;
        MMIO_VALID  = 1'b1;
        tick(1);
        MMIO_VALID  = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        tick(1);
        while (!MMIO_READY && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 64'(MMIO_READY), 64'd1);
    endtask

    task automatic wait_rd_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!RD_REQ_VALID && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 64'(RD_REQ_VALID), 64'd1);
    endtask

    task automatic pulse_done();
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [3:0] l);
        rd_exp.push_back(req_t'{addr: a, len: l});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] l);
        wr_exp.push_back(req_t'{addr: a, len: l});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, w0, pulses, n;

        #23 ARESETN = 1'b1;
        tick(1);
        check("rst_ready", 64'(MMIO_READY), 64'd1);
        check("rst_rd_valid", 64'(RD_REQ_VALID), 64'd0);
        check("rst_wr_valid", 64'(WR_REQ_VALID), 64'd0);
        check("rst_cmd_err", 64'(CMD_ERR), 64'd0);

        // Two full bursts each way, write responses four cycles after handshake.
        push_rd(32'h1000, 4'd15);
        push_rd(32'h1080, 4'd15);
        push_wr(32'h2000, 4'd15);
        push_wr(32'h2080, 4'd15);
        d0 = done_cnt;
        send(32'd1, 32'h1000, 32'h2000, 32'd256);
        wait_ready("t1_complete", 200);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd2);
        check("t1_rd_left", 64'(rd_exp.size()), 64'd0);
        check("t1_wr_left", 64'(wr_exp.size()), 64'd0);

        // 4 KB boundary split on the read side with a stalled read channel.
        RD_REQ_READY = 1'b0;
        push_rd(32'h0FF0, 4'd1);
        push_rd(32'h1000, 4'd5);
        push_wr(32'h5000, 4'd7);
        send(32'd1, 32'h0FF0, 32'h5000, 32'd64);
        wait_rd_valid("t2_rd_valid_seen", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", 64'(RD_REQ_VALID), 64'd1);
            check("t2_stall_addr", 64'(RD_REQ_ADDR), 64'h0FF0);
            check("t2_stall_len", 64'(RD_REQ_LEN), 64'd1);
            tick(1);
        end
        RD_REQ_READY = 1'b1;
        wait_ready("t2_complete", 200);
        check("t2_rd_left", 64'(rd_exp.size()), 64'd0);
        check("t2_wr_left", 64'(wr_exp.size()), 64'd0);

        // Unsupported opcode, then a zero-beat copy.
        r0 = rd_hs;
        w0 = wr_hs;
        send(32'd7, 32'h100, 32'h200, 32'd256);
        check("t3_err_set", 64'(CMD_ERR), 64'd1);
        check("t3_err_ready", 64'(MMIO_READY), 64'd1);
        tick(5);
        send(32'd1, 32'h100, 32'h200, 32'd5);
        check("t3_err_clr", 64'(CMD_ERR), 64'd0);
        check("t3_zero_ready", 64'(MMIO_READY), 64'd1);
        tick(5);
        check("t3_no_rd", 64'(rd_hs - r0), 64'd0);
        check("t3_no_wr", 64'(wr_hs - w0), 64'd0);

        // Outstanding write limit with manually controlled responses.
        auto_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push_rd(32'h10000 + 32'(i) * 32'h80, 4'd15);
            push_wr(32'h20000 + 32'(i) * 32'h80, 4'd15);
        end
        w0 = wr_hs;
        send(32'd1, 32'h10000, 32'h20000, 32'd4096);
        tick(60);
        check("t4_cap_count", 64'(wr_hs - w0), 64'd8);
        check("t4_cap_valid", 64'(WR_REQ_VALID), 64'd0);
        check("t4_busy", 64'(MMIO_READY), 64'd0);
        pulse_done();
        tick(6);
        check("t4_one_more", 64'(wr_hs - w0), 64'd9);
        check("t4_one_more_valid", 64'(WR_REQ_VALID), 64'd0);
        pulse_done();
        n = 0;
        while (!WR_REQ_VALID && n < 20) begin
            tick(1);
            n++;
        end
        check("t4_refill_valid", 64'(WR_REQ_VALID), 64'd1);
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
        tick(6);
        check("t4_same_cycle_count", 64'(wr_hs - w0), 64'd11);
        check("t4_same_cycle_valid", 64'(WR_REQ_VALID), 64'd0);
        pulses = 3;
        while (!MMIO_READY && pulses < 60) begin
            pulse_done();
            pulses++;
            tick(3);
        end
        check("t4_pulses", 64'(pulses), 64'd32);
        check("t4_complete", 64'(MMIO_READY), 64'd1);
        check("t4_rd_left", 64'(rd_exp.size()), 64'd0);
        check("t4_wr_left", 64'(wr_exp.size()), 64'd0);
        auto_en = 1'b1;

        // Asynchronous reset in the middle of ISSUE.
        RD_REQ_READY = 1'b0;
        send(32'd1, 32'h3000, 32'h4000, 32'd1024);
        wait_rd_valid("t5_rd_valid_seen", 20);
        #2 ARESETN = 1'b0;
        #1;
        check("t5_ready", 64'(MMIO_READY), 64'd1);
        check("t5_rd_valid", 64'(RD_REQ_VALID), 64'd0);
        check("t5_wr_valid", 64'(WR_REQ_VALID), 64'd0);
        check("t5_rd_addr", 64'(RD_REQ_ADDR), 64'd0);
        check("t5_wr_addr", 64'(WR_REQ_ADDR), 64'd0);
        check("t5_rd_len", 64'(RD_REQ_LEN), 64'd0);
        check("t5_wr_len", 64'(WR_REQ_LEN), 64'd0);
        check("t5_cmd_err", 64'(CMD_ERR), 64'd0);
        rd_exp.delete();
        wr_exp.delete();
        RD_REQ_READY = 1'b1;
        tick(2);
        ARESETN = 1'b1;
        tick(2);
        check("t5_post_ready", 64'(MMIO_READY), 64'd1);

        // Recovery: one short command after the reset.
        push_rd(32'h0100, 4'd7);
        push_wr(32'h0200, 4'd7);
        send(32'd1, 32'h0104, 32'h0203, 32'd70);
        wait_ready("t6_complete", 200);
        check("t6_rd_left", 64'(rd_exp.size()), 64'd0);
        check("t6_wr_left", 64'(wr_exp.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_burst_gen.md
Name: stream_burst_gen

Overview:
- Sits directly downstream of the MMIO command register block.
- Consumes its MMIO_VALID/MMIO_READY handshake and the MMIO_CMD, STREAM_SRC, STREAM_DEST and STREAM_LEN fields.
- Splits each copy command into AXI3-legal read and write burst requests (address plus beat count) for the DMA datapath.
- Holds MMIO_READY low until every burst has been issued and every write burst has been acknowledged. This drives the command block's cycle counter and IRQ.

Parameters:
- BPB, 8, bytes per data beat (power of 2); addresses and length are truncated to BPB alignment.
- MAX_BURST, 16, maximum beats per burst (≤16, AXI3).
- MAX_OUTSTANDING, 8, maximum write bursts issued but not yet acknowledged.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- MMIO_VALID  in  1  command valid.
- MMIO_READY  out  1  high = idle and accepting a command.
- MMIO_CMD  in  32  opcode; only [7:0] is decoded.
- STREAM_SRC  in  32  read start byte address.
- STREAM_DEST  in  32  write start byte address.
- STREAM_LEN  in  32  transfer length in bytes.
- RD_REQ_VALID  out  1  read burst request valid.
- RD_REQ_READY  in  1  read burst request accepted.
- RD_REQ_ADDR  out  32  read burst byte address.
- RD_REQ_LEN  out  4  read burst beats minus 1.
- WR_REQ_VALID  out  1  write burst request valid.
- WR_REQ_READY  in  1  write burst request accepted.
- WR_REQ_ADDR  out  32  write burst byte address.
- WR_REQ_LEN  out  4  write burst beats minus 1.
- WR_DONE  in  1  one-cycle pulse per write burst response received.
- CMD_ERR  out  1  sticky: last command had an unsupported opcode.

Behaviour:
- Reset (ARESETN low, asynchronous) forces these values, regardless of any operation in progress: state IDLE, MMIO_READY=1, RD_REQ_VALID=0, WR_REQ_VALID=0, all address and length outputs 0, CMD_ERR=0, outstanding count 0. Any command in progress is abandoned.
- States: IDLE, ISSUE, DRAIN. MMIO_READY=1 only in IDLE.
- IDLE, when MMIO_VALID=1 (the accept cycle):
  - Latch src/dest with the low log2(BPB) bits cleared.
  - Latch beats = STREAM_LEN >> log2(BPB) (remainder bytes are dropped).
  - CMD_ERR ← (CMD[7:0] not in {0,1}).
  - If CMD[7:0]==1 and beats≠0: go to ISSUE. Otherwise stay in IDLE (NOP, zero length, or error). MMIO_READY stays 1, so the command completes in one cycle.
- ISSUE: the read and write generators run independently, each with its own address and remaining-beat counter.
  - Burst size n = min(remaining, MAX_BURST, (4096 − addr[11:0]) / BPB). A burst never crosses a 4 KB boundary.
  - Request VALID is registered and stays stable until the READY handshake completes; ADDR and LEN do not change while VALID=1 and READY=0.
  - On handshake: addr += n·BPB, remaining −= n. The next request may assert on the following cycle at the earliest.
  - The write generator holds WR_REQ_VALID=0 while outstanding == MAX_OUTSTANDING.
- Outstanding counter: +1 on a write handshake, −1 on WR_DONE. Both in the same cycle leaves it unchanged. WR_DONE with outstanding==0 is ignored (counter saturates at 0).
- ISSUE → DRAIN when both remaining counters are 0 and both VALIDs are low. DRAIN → IDLE on the cycle outstanding reaches 0; MMIO_READY goes 1 on the next cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32 without flagging.
- MMIO_VALID is ignored outside IDLE.

Test Plan:
- Reset → MMIO_READY=1, both REQ_VALIDs 0, CMD_ERR=0. Assert ARESETN low mid-ISSUE → all outputs return to reset values immediately, without waiting for a clock edge.
- CMD=1, SRC=0x1000, DEST=0x2000, LEN=256, READYs tied 1, WR_DONE 4 cycles after each write handshake → reads at 0x1000/0x1080 and writes at 0x2000/0x2080, LEN=15 each; MMIO_READY returns to 1 after the second WR_DONE.
- CMD=1, SRC=0x0FF0, DEST=0x5000, LEN=64 → reads 0x0FF0 LEN=1, then 0x1000 LEN=5; write 0x5000 LEN=7.
- CMD=1, LEN=4096, WR_REQ_READY=1, WR_DONE withheld → exactly 8 write requests issued, then WR_REQ_VALID=0. One WR_DONE pulse → one more write request. Command completes only after 32 WR_DONE pulses.
- RD_REQ_READY held 0 for 5 cycles → RD_REQ_VALID, ADDR and LEN stay stable throughout. WR_DONE and a write handshake in the same cycle → outstanding count unchanged.
- CMD=7 → CMD_ERR=1, no requests, MMIO_READY stays 1. Next CMD=1 with LEN=5 → CMD_ERR=0, no requests (0 beats), command completes immediately.
